// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: instruction fields, opcodes and hazard-control FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        LW    = 6'b100011,
        SW    = 6'b101011,
        LL    = 6'b110000,
        SC    = 6'b111000,
        HALT  = 6'b111111
    } opcode_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } hazard_state_t;

    function automatic logic [5:0] op_of(input word_t instr);
        return instr[31:26];
    endfunction

    function automatic regbits_t rs_of(input word_t instr);
        return instr[25:21];
    endfunction

    function automatic regbits_t rt_of(input word_t instr);
        return instr[20:16];
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Signal bundle for the hazard unit; hu is the design view, tb the mirrored driver view.
interface hazard_unit_if
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             CLK;
    logic             RST;
    logic             ihit;
    logic             dhit;
    word_t            ifid_instr;
    word_t            idex_instr;
    logic             exmem_dREN;
    logic             exmem_dWEN;
    logic             exmem_pcsrc;
    logic             exmem_halt;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport hu (
        input  CLK, RST, ihit, dhit, ifid_instr, idex_instr,
               exmem_dREN, exmem_dWEN, exmem_pcsrc, exmem_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_cnt, flush_cnt
    );

    modport tb (
        output CLK, RST, ihit, dhit, ifid_instr, idex_instr,
               exmem_dREN, exmem_dWEN, exmem_pcsrc, exmem_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);
    logic [W-1:0] r_count;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush control: dmem wait, taken branch, load-use, imem wait and halt,
// with saturating stall/flush event counters.
module hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  word_t            ifid_instr,
    input  word_t            idex_instr,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             exmem_pcsrc,
    input  logic             exmem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    hazard_state_t r_state, w_state_next;

    logic w_dwait;
    logic w_ifid_uses_rt;
    logic w_idex_is_load;
    logic w_load_use;
    logic w_stall_inc;
    logic w_flush_inc;
    logic w_unused;

    assign w_dwait        = (exmem_dREN | exmem_dWEN) & ~dhit;
    assign w_ifid_uses_rt = op_of(ifid_instr) inside {RTYPE, SW, SC, BEQ, BNE};
    assign w_idex_is_load = op_of(idex_instr) inside {LW, LL};
    assign w_load_use     = w_idex_is_load && (rt_of(idex_instr) != '0) &&
                            ((rt_of(idex_instr) == rs_of(ifid_instr)) ||
                             (w_ifid_uses_rt && (rt_of(idex_instr) == rt_of(ifid_instr))));
    assign w_unused       = ^{ifid_instr[15:0], idex_instr[25:21], idex_instr[15:0]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_en     = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        halted       = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        // Gating on RST keeps every output low for the whole reset pulse, not just after the edge.
        if (!RST) begin
            case (r_state)
                RUN: begin
                    if (exmem_halt && !w_dwait) w_state_next = HALTED;
                    if (w_dwait) begin
                        w_stall_inc = 1'b1;
                    end else if (exmem_pcsrc) begin
                        pc_en       = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                        memwb_en    = 1'b1;
                        w_flush_inc = 1'b1;
                    end else if (w_load_use) begin
                        idex_flush  = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        w_stall_inc = 1'b1;
                    end else if (!ihit) begin
                        ifid_flush  = 1'b1;
                        idex_en     = 1'b1;
                        exmem_en    = 1'b1;
                        memwb_en    = 1'b1;
                        w_stall_inc = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_stall_inc),
        .clear (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (w_flush_inc),
        .clear (1'b0),
        .count (flush_cnt)
    );
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit: priorities, halt, async reset, saturation.
module tb_hazard_unit;
    import cpu_types_pkg::*;

    hazard_unit_if #(.CNT_W(16)) hif ();

    logic       rst_s;
    logic       pc_s, ifid_s, idex_s, exmem_s, memwb_s;
    logic       iff_s, idf_s, exf_s, halted_s;
    logic [3:0] stall_s, flush_s;

    logic [8:0] w_outs;
    logic [8:0] w_outs_s;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_unit #(.CNT_W(16)) dut (
        .CLK         (hif.CLK),
        .RST         (hif.RST),
        .ihit        (hif.ihit),
        .dhit        (hif.dhit),
        .ifid_instr  (hif.ifid_instr),
        .idex_instr  (hif.idex_instr),
        .exmem_dREN  (hif.exmem_dREN),
        .exmem_dWEN  (hif.exmem_dWEN),
        .exmem_pcsrc (hif.exmem_pcsrc),
        .exmem_halt  (hif.exmem_halt),
        .pc_en       (hif.pc_en),
        .ifid_en     (hif.ifid_en),
        .idex_en     (hif.idex_en),
        .exmem_en    (hif.exmem_en),
        .memwb_en    (hif.memwb_en),
        .ifid_flush  (hif.ifid_flush),
        .idex_flush  (hif.idex_flush),
        .exmem_flush (hif.exmem_flush),
        .halted      (hif.halted),
        .stall_cnt   (hif.stall_cnt),
        .flush_cnt   (hif.flush_cnt)
    );

    hazard_unit #(.CNT_W(4)) dut_sat (
        .CLK         (hif.CLK),
        .RST         (rst_s),
        .ihit        (hif.ihit),
        .dhit        (hif.dhit),
        .ifid_instr  (hif.ifid_instr),
        .idex_instr  (hif.idex_instr),
        .exmem_dREN  (hif.exmem_dREN),
        .exmem_dWEN  (hif.exmem_dWEN),
        .exmem_pcsrc (hif.exmem_pcsrc),
        .exmem_halt  (hif.exmem_halt),
        .pc_en       (pc_s),
        .ifid_en     (ifid_s),
        .idex_en     (idex_s),
        .exmem_en    (exmem_s),
        .memwb_en    (memwb_s),
        .ifid_flush  (iff_s),
        .idex_flush  (idf_s),
        .exmem_flush (exf_s),
        .halted      (halted_s),
        .stall_cnt   (stall_s),
        .flush_cnt   (flush_s)
    );

    // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl, halted}
    assign w_outs   = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                       hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.halted};
    assign w_outs_s = {pc_s, ifid_s, idex_s, exmem_s, memwb_s, iff_s, idf_s, exf_s, halted_s};

    initial begin
        hif.CLK = 1'b0;
        forever #5 hif.CLK = ~hif.CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic word_t mk(input logic [5:0] op, input int rs, input int rt);
        return {op, rs[4:0], rt[4:0], 16'h0000};
    endfunction

    task automatic set_in(input logic ih, input logic dh, input logic drn, input logic dwn,
                          input logic pcs, input logic hlt, input word_t ifid, input word_t idex);
        hif.ihit        = ih;
        hif.dhit        = dh;
        hif.exmem_dREN  = drn;
        hif.exmem_dWEN  = dwn;
        hif.exmem_pcsrc = pcs;
        hif.exmem_halt  = hlt;
        hif.ifid_instr  = ifid;
        hif.idex_instr  = idex;
    endtask

    task automatic step(input string tag, input logic [8:0] exp_o, input bit s_inc, input bit f_inc);
        @(negedge hif.CLK);
        check({tag, ".outs"}, {23'd0, w_outs}, {23'd0, exp_o});
        @(posedge hif.CLK);
        #1;
        if (s_inc && exp_stall < 65535) exp_stall++;
        if (f_inc && exp_flush < 65535) exp_flush++;
        check({tag, ".stall"}, {16'd0, hif.stall_cnt}, exp_stall);
        check({tag, ".flush"}, {16'd0, hif.flush_cnt}, exp_flush);
    endtask

    localparam logic [8:0] O_IDLE  = 9'b11111_000_0;
    localparam logic [8:0] O_LU    = 9'b00011_010_0;
    localparam logic [8:0] O_BR    = 9'b10001_111_0;
    localparam logic [8:0] O_IMISS = 9'b00111_100_0;
    localparam logic [8:0] O_ZERO  = 9'b00000_000_0;
    localparam logic [8:0] O_HALT  = 9'b00000_000_1;

    initial begin
        word_t lw_t0, add_t0, nop;
        nop    = '0;
        lw_t0  = mk(LW, 29, 8);
        add_t0 = mk(RTYPE, 8, 10);

        rst_s   = 1'b1;
        hif.RST = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nop, nop);
        #2;
        check("reset.outs", {23'd0, w_outs}, 32'd0);
        check("reset.stall", {16'd0, hif.stall_cnt}, 32'd0);
        check("reset.flush", {16'd0, hif.flush_cnt}, 32'd0);
        @(negedge hif.CLK);
        hif.RST = 1'b0;

        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nop, nop);
        step("idle", O_IDLE, 0, 0);

        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add_t0, lw_t0);
        step("lu_rs", O_LU, 1, 0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add_t0, nop);
        step("lu_bubble", O_IDLE, 0, 0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(SW, 5, 8), mk(LL, 3, 8));
        step("lu_sw_rt", O_LU, 1, 0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(6'b001000, 5, 8), lw_t0);
        step("itype_rt", O_IDLE, 0, 0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(RTYPE, 0, 0), mk(LW, 29, 0));
        step("lu_rt0", O_IDLE, 0, 0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(BEQ, 1, 8), lw_t0);
        step("lu_beq_rt", O_LU, 1, 0);

        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, nop, nop);
        step("br_imiss", O_BR, 0, 1);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nop, nop);
        step("imiss", O_IMISS, 1, 0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, add_t0, lw_t0);
        step("br_over_lu", O_BR, 0, 1);

        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, add_t0, lw_t0);
        for (int unsigned i = 0; i < 3; i++) step("dwait", O_ZERO, 1, 0);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, add_t0, lw_t0);
        step("dwait_done_br", O_BR, 0, 1);

        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, nop, nop);
        step("halt_dwait", O_ZERO, 1, 0);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, nop, nop);
        step("halt_entry", O_IDLE, 0, 0);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, add_t0, lw_t0);
        step("halted_a", O_HALT, 0, 0);
        step("halted_b", O_HALT, 0, 0);

        @(negedge hif.CLK);
        #2 hif.RST = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check("halt_rst.outs", {23'd0, w_outs}, 32'd0);
        check("halt_rst.stall", {16'd0, hif.stall_cnt}, 32'd0);
        check("halt_rst.flush", {16'd0, hif.flush_cnt}, 32'd0);
        #1 hif.RST = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nop, nop);
        step("post_rst", O_IDLE, 0, 0);

        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, add_t0, lw_t0);
        @(negedge hif.CLK);
        check("midstall.pre", {23'd0, w_outs}, {23'd0, O_LU});
        #2 hif.RST = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check("midstall.outs", {23'd0, w_outs}, 32'd0);
        check("midstall.stall", {16'd0, hif.stall_cnt}, 32'd0);
        #1 hif.RST = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nop, nop);
        step("post_rst2", O_IDLE, 0, 0);

        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, nop, nop);
        rst_s = 1'b0;
        for (int unsigned i = 1; i <= 20; i++) begin
            @(negedge hif.CLK);
            if (i == 1) check("sat.outs", {23'd0, w_outs_s}, {23'd0, O_IMISS});
            @(posedge hif.CLK);
            #1;
            check("sat.stall", {28'd0, stall_s}, (i < 15) ? i : 32'd15);
        end
        check("sat.flush", {28'd0, flush_s}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline control block for the 5-stage datapath. It is the stall/flush counterpart to forwarding: forwarding resolves data hazards by bypass, and this block handles what bypass cannot. It drives every pipeline-register enable and flush from:
- load-use hazards,
- instruction/data cache wait,
- taken branches/jumps resolved in MEM,
- halt.

It also keeps saturating stall/flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction cache returned fetch this cycle
- dhit  in  1  data cache completed MEM-stage access this cycle
- ifid_instr  in  32 (word_t)  instruction in ID
- idex_instr  in  32 (word_t)  instruction in EX
- exmem_dREN, exmem_dWEN  in  1 each  MEM-stage data request
- exmem_pcsrc  in  1  taken branch or jump resolved in MEM
- exmem_halt  in  1  HALT in MEM
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous load of NOP (flush wins over enable)
- halted  out  1  sticky halt indicator
- stall_cnt, flush_cnt  out  CNT_W each  event counters

## Operation
- FSM states, registered: RUN, HALTED.
- RST high:
  - state goes to RUN; counters go to 0.
  - All outputs go to 0 immediately: enables, flushes, halted.
- HALTED:
  - Entered on any clock edge where state is RUN and exmem_halt=1 (and dmem is not waiting).
  - While HALTED: all enables 0, all flushes 0, halted=1, counters frozen.
  - Left only by RST.
- In RUN, outputs are combinational. Conditions are evaluated in priority order; the first true one applies.
  1. **dwait** = (exmem_dREN|exmem_dWEN) & !dhit.
     - All enables 0, no flush.
     - stall_cnt +1.
  2. **exmem_pcsrc.**
     - pc_en=1 (loads target regardless of ihit; pending fetch abandoned).
     - ifid_flush, idex_flush, exmem_flush = 1.
     - memwb_en=1.
     - flush_cnt +1.
  3. **Load-use.** Condition: idex opcode is LW or LL, idex rt != 0, and idex rt equals either:
     - ifid rs, or
     - ifid rt, when ifid is R-type, SW, SC, BEQ or BNE.

     Response:
     - pc_en=0, ifid_en=0, idex_flush=1.
     - exmem_en=1, memwb_en=1.
     - stall_cnt +1.
  4. **!ihit.**
     - pc_en=0, ifid_flush=1.
     - idex_en, exmem_en, memwb_en = 1.
     - stall_cnt +1.
  5. **Otherwise.** All enables 1, no flush.
- exmem_halt with dwait: halt entry is deferred until dwait clears.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - At most one increment per counter per cycle.
- Load-use stalls for exactly one cycle by construction: the bubble reaches EX, so the condition clears on the next cycle.

## Timing
- Enable/flush outputs: combinational, same cycle as the inputs; no added latency.
- State and counters update on the rising CLK edge.
- Reset takes effect asynchronously, with no clock edge needed. Release is synchronous to the next CLK edge.
- Taken branch: exactly 3 squashed instructions (ID, EX, MEM); the target is fetched the following cycle.

## Structure
- cpu_types_pkg:
  - already holds word_t, regbits_t and opcode_t (LW, LL, SW, SC, BEQ, BNE, RTYPE);
  - add hazard_state_t (RUN, HALTED).
- hazard_unit_if.vh interface:
  - modport hu, for the inputs/outputs above;
  - modport tb, mirrored.
- One sub-module: sat_counter (parameter W; inc, clear; saturating), instantiated twice.

## Test plan
- Load-use: idex = LW $t0 (rt=8), ifid = ADD $t1,$t0,$t2, ihit=dhit=1.
  - Required: pc_en=0, ifid_en=0, idex_flush=1, stall_cnt 0->1.
  - Next cycle, with idex = NOP: all enables 1.
  - Repeat with rt=0: no stall.
- Branch during ihit=0: exmem_pcsrc=1, ihit=0.
  - Required: pc_en=1, three flushes=1, flush_cnt +1, stall_cnt unchanged.
- dwait beats everything: exmem_dREN=1, dhit=0, exmem_pcsrc=1, load-use present, for 3 cycles.
  - Required: all enables 0, no flush, stall_cnt +3.
  - When dhit=1: branch flush applies.
- Halt: exmem_halt=1, no dwait.
  - Required: halted=1 after the edge, then all enables 0 forever.
  - RST pulse mid-cycle: halted=0 immediately, counters 0.
- Saturation: CNT_W=4, hold ihit=0 for 20 cycles.
  - Required: stall_cnt stops at 15.
- Reset mid-stall: assert RST during load-use.
  - Required: outputs go to 0 asynchronously, before the next edge.
